monster_move_ctrl: RTL and testbench

- Per-monster motion controller. It consumes the per-pixel collision pulse and the 4-bit hit-edge code produced by the monster bitmap/collision path during each frame.
- At every start-of-frame it resolves wall bounces and periodic pseudo-random turns, then advances the monster's top-left position.
- Its position outputs feed the monster's rectangle/offset generator, which closes the loop back into the bitmap.

---
 rtl/monster_pkg.sv | 41 ++++
 rtl/monster_move_ctrl_lfsr8.sv | 23 ++
 rtl/monster_move_ctrl.sv | 177 +++++++++++++++++
 tb/tb_monster_move_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/monster_pkg.sv
// Shared types and screen geometry for the monster motion blocks.
// Edge-code bit positions follow the {Left,Top,Right,Bottom} order of the collision path.
package monster_pkg;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_UP    = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        S_WAIT    = 2'd0,
        S_RESOLVE = 2'd1,
        S_MOVE    = 2'd2
    } move_state_t;

    localparam int HIT_LEFT   = 3;
    localparam int HIT_TOP    = 2;
    localparam int HIT_RIGHT  = 1;
    localparam int HIT_BOTTOM = 0;

    localparam int OBJ_SIZE = 32;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // A wall blocks the current heading when the edge facing that heading was hit.
    function automatic logic is_blocked(input logic [3:0] snap, input dir_t d);
        case (d)
            DIR_RIGHT: return snap[HIT_RIGHT];
            DIR_UP:    return snap[HIT_TOP];
            DIR_LEFT:  return snap[HIT_LEFT];
            default:   return snap[HIT_BOTTOM];
        endcase
    endfunction

    function automatic dir_t reverse_dir(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

endpackage

// File: rtl/monster_move_ctrl_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) that advances only when enabled.
// The seed must be non-zero; the all-zero state is a lock-up point.
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [7:0] q
);

    logic feedback;

    assign feedback = q[7] ^ q[5] ^ q[4] ^ q[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= SEED;
        else if (en)
            q <= {q[6:0], feedback};
    end

endmodule

// File: rtl/monster_move_ctrl.sv
// Per-monster motion controller: gathers wall hits during a frame, then at start-of-frame
// resolves bounces / random turns and advances the top-left position by SPEED pixels.
module monster_move_ctrl
    import monster_pkg::*;
#(
    parameter logic [10:0] INIT_X      = 11'd288,
    parameter logic [10:0] INIT_Y      = 11'd224,
    parameter logic [1:0]  INIT_DIR    = 2'd0,
    parameter logic [3:0]  SPEED       = 4'd2,
    parameter logic [7:0]  TURN_FRAMES = 8'd60,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5,
    parameter logic [10:0] MAX_X       = 11'(SCREEN_W - OBJ_SIZE),
    parameter logic [10:0] MAX_Y       = 11'(SCREEN_H - OBJ_SIZE)
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        collision,
    input  logic [3:0]  HitEdgeCode,
    input  logic        freeze,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic [1:0]  dirCode,
    output logic        bounced
);

    localparam logic signed [11:0] MAX_X_S = signed'({1'b0, MAX_X});
    localparam logic signed [11:0] MAX_Y_S = signed'({1'b0, MAX_Y});
    localparam logic signed [11:0] STEP    = signed'({8'd0, SPEED});

    move_state_t state, state_next;
    dir_t        dir_q;
    logic [3:0]  hit_acc;
    logic [3:0]  hit_snap;
    logic [7:0]  frame_cnt;
    logic [7:0]  lfsr_q;
    logic [5:0]  lfsr_unused;

    logic sof_accept;
    logic resolve_bounce;
    logic resolve_turn;
    logic resolve_count;
    logic move_en;

    logic signed [11:0] x_ext, y_ext, x_sum, y_sum;
    logic [10:0]        x_new, y_new;
    logic               clamped;

    assign dirCode     = dir_q;
    assign sof_accept  = (state == S_WAIT) && startOfFrame;
    assign lfsr_unused = lfsr_q[7:2];

    lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (resetN),
        .en    (resolve_turn),
        .q     (lfsr_q)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            state <= S_WAIT;
        else
            state <= state_next;
    end

    // Bounce outranks the periodic turn; a frozen frame skips both and the frame counter.
    always_comb begin
        state_next     = state;
        resolve_bounce = 1'b0;
        resolve_turn   = 1'b0;
        resolve_count  = 1'b0;
        move_en        = 1'b0;
        case (state)
            S_WAIT: begin
                if (startOfFrame)
                    state_next = S_RESOLVE;
            end
            S_RESOLVE: begin
                state_next = S_MOVE;
                if (freeze)
                    state_next = S_WAIT;
                else if (is_blocked(hit_snap, dir_q))
                    resolve_bounce = 1'b1;
                else if (frame_cnt == TURN_FRAMES - 8'd1)
                    resolve_turn = 1'b1;
                else
                    resolve_count = 1'b1;
            end
            S_MOVE: begin
                state_next = S_WAIT;
                move_en    = 1'b1;
            end
            default: state_next = S_WAIT;
        endcase
    end

    assign x_ext = signed'({1'b0, topLeftX});
    assign y_ext = signed'({1'b0, topLeftY});

    always_comb begin
        x_sum = x_ext;
        y_sum = y_ext;
        case (dir_q)
            DIR_RIGHT: x_sum = x_ext + STEP;
            DIR_UP:    y_sum = y_ext - STEP;
            DIR_LEFT:  x_sum = x_ext - STEP;
            default:   y_sum = y_ext + STEP;
        endcase
    end

    // Signed sums let a step past the left/top edge show up as negative before clamping.
    always_comb begin
        x_new   = x_sum[10:0];
        y_new   = y_sum[10:0];
        clamped = 1'b0;
        if (x_sum < 12'sd0) begin
            x_new   = '0;
            clamped = 1'b1;
        end else if (x_sum > MAX_X_S) begin
            x_new   = MAX_X;
            clamped = 1'b1;
        end
        if (y_sum < 12'sd0) begin
            y_new   = '0;
            clamped = 1'b1;
        end else if (y_sum > MAX_Y_S) begin
            y_new   = MAX_Y;
            clamped = 1'b1;
        end
    end

    // A hit landing in the start-of-frame cycle belongs to the fresh accumulator.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            topLeftX  <= INIT_X;
            topLeftY  <= INIT_Y;
            dir_q     <= dir_t'(INIT_DIR);
            bounced   <= 1'b0;
            hit_acc   <= '0;
            hit_snap  <= '0;
            frame_cnt <= '0;
        end else begin
            bounced <= 1'b0;

            if (sof_accept) begin
                hit_snap <= hit_acc;
                hit_acc  <= collision ? HitEdgeCode : 4'h0;
            end else if (collision) begin
                hit_acc <= hit_acc | HitEdgeCode;
            end

            if (resolve_bounce) begin
                dir_q     <= reverse_dir(dir_q);
                bounced   <= 1'b1;
                frame_cnt <= '0;
            end else if (resolve_turn) begin
                dir_q     <= dir_t'(lfsr_q[1:0]);
                frame_cnt <= '0;
            end else if (resolve_count) begin
                frame_cnt <= frame_cnt + 8'd1;
            end

            if (move_en) begin
                topLeftX <= x_new;
                topLeftY <= y_new;
                if (clamped) begin
                    dir_q   <= reverse_dir(dir_q);
                    bounced <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_monster_move_ctrl.sv
// Directed bench: a default-parameter controller for motion/bounce/freeze/reset,
// and a short-turn-period instance started near the left wall for clamping and LFSR turns.
module tb_monster_move_ctrl;

    logic       clk = 1'b0;
    logic       rstA = 1'b0;
    logic       rstB = 1'b0;
    logic       startOfFrame = 1'b0;
    logic       collision = 1'b0;
    logic [3:0] hitEdgeCode = 4'h0;
    logic       freeze = 1'b0;

    logic [10:0] xA, yA, xB, yB;
    logic [1:0]  dirA, dirB;
    logic        bncA, bncB;

    int vectors = 0;
    int miscompares = 0;

    int xEarlyA;
    int bResA, bMovA, bAftA;
    int bResB, bMovB, bAftB;

    logic [7:0] lfsrRef = 8'hA5;

    always #5 clk = ~clk;

    monster_move_ctrl dutA (
        .clk          (clk),
        .resetN       (rstA),
        .startOfFrame (startOfFrame),
        .collision    (collision),
        .HitEdgeCode  (hitEdgeCode),
        .freeze       (freeze),
        .topLeftX     (xA),
        .topLeftY     (yA),
        .dirCode      (dirA),
        .bounced      (bncA)
    );

    monster_move_ctrl #(
        .INIT_X      (11'd1),
        .INIT_DIR    (2'd2),
        .TURN_FRAMES (8'd4)
    ) dutB (
        .clk          (clk),
        .resetN       (rstB),
        .startOfFrame (startOfFrame),
        .collision    (collision),
        .HitEdgeCode  (hitEdgeCode),
        .freeze       (freeze),
        .topLeftX     (xB),
        .topLeftY     (yB),
        .dirCode      (dirB),
        .bounced      (bncB)
    );

    function automatic logic [7:0] lfsrStep(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    task automatic checkOutput(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One frame: optional mid-frame hit, then a start-of-frame pulse (optionally with a hit
    // in that same cycle); bounced is captured after resolve, after move, and one cycle later.
    task automatic applyStimulus(input logic [3:0] hit, input logic [3:0] sofHit);
        @(negedge clk);
        collision   = (hit != 4'h0);
        hitEdgeCode = hit;
        @(negedge clk);
        collision   = 1'b0;
        hitEdgeCode = 4'h0;
        repeat (2) @(negedge clk);
        startOfFrame = 1'b1;
        collision    = (sofHit != 4'h0);
        hitEdgeCode  = sofHit;
        @(negedge clk);
        startOfFrame = 1'b0;
        collision    = 1'b0;
        hitEdgeCode  = 4'h0;
        @(negedge clk);
        bResA   = int'(bncA);
        bResB   = int'(bncB);
        xEarlyA = int'(xA);
        @(negedge clk);
        bMovA = int'(bncA);
        bMovB = int'(bncB);
        @(negedge clk);
        bAftA = int'(bncA);
        bAftB = int'(bncB);
    endtask

    int aHit [18] = '{0, 0, 0, 0, 0, 0, 2, 8, 8, 2, 0, 0, 15, 15, 15, 15, 15, 0};
    int aSof [18] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 0, 0, 0, 0, 0, 0, 0};
    int aFrz [18] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0};
    int aX   [18] = '{290, 292, 294, 296, 298, 300, 298, 300, 302, 300, 298, 300,
                      300, 300, 300, 300, 300, 302};
    int aDir [18] = '{0, 0, 0, 0, 0, 0, 2, 0, 0, 2, 2, 0, 0, 0, 0, 0, 0, 0};
    int aBnc [18] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0};

    int bX   [20] = '{0, 2, 4, 4, 4, 4, 4, 2, 0, 0, 2, 2, 2, 2, 2, 2, 2, 2, 2, 0};
    int bY   [20] = '{224, 224, 224, 222, 220, 218, 216, 216, 216, 216,
                      216, 214, 212, 210, 208, 210, 212, 214, 216, 216};
    int bDir [20] = '{0, 0, 0, 1, 1, 1, 1, 2, 2, 0, 0, 1, 1, 1, 1, 3, 3, 3, 3, 2};
    int bRes [20] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    int bMov [20] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    initial begin
        repeat (2) @(negedge clk);
        rstA = 1'b1;
        @(negedge clk);
        checkOutput("A reset X", int'(xA), 288);
        checkOutput("A reset Y", int'(yA), 224);
        checkOutput("A reset dir", int'(dirA), 0);
        checkOutput("A reset bounced", int'(bncA), 0);

        for (int i = 0; i < 18; i++) begin
            freeze = aFrz[i][0];
            applyStimulus(aHit[i][3:0], aSof[i][3:0]);
            if (i == 0)
                checkOutput("A X before move", xEarlyA, 288);
            checkOutput($sformatf("A f%0d X", i + 1), int'(xA), aX[i]);
            checkOutput($sformatf("A f%0d Y", i + 1), int'(yA), 224);
            checkOutput($sformatf("A f%0d dir", i + 1), int'(dirA), aDir[i]);
            checkOutput($sformatf("A f%0d bnc resolve", i + 1), bResA, aBnc[i]);
            checkOutput($sformatf("A f%0d bnc move", i + 1), bMovA, 0);
            checkOutput($sformatf("A f%0d bnc after", i + 1), bAftA, 0);
        end
        freeze = 1'b0;

        @(negedge clk);
        collision   = 1'b1;
        hitEdgeCode = 4'hF;
        #2 rstA = 1'b0;
        #1;
        checkOutput("A async reset X", int'(xA), 288);
        checkOutput("A async reset Y", int'(yA), 224);
        checkOutput("A async reset dir", int'(dirA), 0);
        checkOutput("A async reset bounced", int'(bncA), 0);
        @(negedge clk);
        collision   = 1'b0;
        hitEdgeCode = 4'h0;
        checkOutput("A held reset X", int'(xA), 288);
        rstA = 1'b1;
        applyStimulus(4'h0, 4'h0);
        checkOutput("A post-reset X", int'(xA), 290);
        checkOutput("A post-reset dir", int'(dirA), 0);
        checkOutput("A post-reset bnc", bResA, 0);

        rstA = 1'b0;
        @(negedge clk);
        rstB = 1'b1;
        @(negedge clk);
        checkOutput("B reset X", int'(xB), 1);
        checkOutput("B reset Y", int'(yB), 224);
        checkOutput("B reset dir", int'(dirB), 2);
        checkOutput("B reset bounced", int'(bncB), 0);

        for (int f = 1; f <= 20; f++) begin
            int expDir;
            applyStimulus((f == 16) ? 4'h4 : 4'h0, 4'h0);
            expDir = bDir[f - 1];
            if (f == 4 || f == 8 || f == 12 || f == 20) begin
                expDir  = int'(lfsrRef[1:0]);
                lfsrRef = lfsrStep(lfsrRef);
            end
            checkOutput($sformatf("B f%0d X", f), int'(xB), bX[f - 1]);
            checkOutput($sformatf("B f%0d Y", f), int'(yB), bY[f - 1]);
            checkOutput($sformatf("B f%0d dir", f), int'(dirB), expDir);
            checkOutput($sformatf("B f%0d bnc resolve", f), bResB, bRes[f - 1]);
            checkOutput($sformatf("B f%0d bnc move", f), bMovB, bMov[f - 1]);
            checkOutput($sformatf("B f%0d bnc after", f), bAftB, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
